// File: rtl/integral_image_stream_pkg.sv
// Shared widths, coordinate helper and width functions for the integral-image stream.
// Imported by the interface, the line memory and the top.
package integral_pkg;

    localparam int unsigned DEF_DIN_W   = 8;
    localparam int unsigned DEF_DOUT_W  = 28;
    localparam int unsigned DEF_DSQ_W   = 36;
    localparam int unsigned DEF_ROWS    = 480;
    localparam int unsigned DEF_COLS    = 640;
    localparam int unsigned MAX_COORD_W = 12;

    typedef struct packed {
        logic [MAX_COORD_W-1:0] col;
        logic [MAX_COORD_W-1:0] row;
    } coord_t;

    function automatic int unsigned col_w(input int unsigned cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

    function automatic int unsigned row_w(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic coord_t make_coord(input int unsigned col, input int unsigned row);
        coord_t c;
        c.col = MAX_COORD_W'(col);
        c.row = MAX_COORD_W'(row);
        return c;
    endfunction

endpackage

// File: rtl/integral_image_stream_if.sv
// Pixel-in / integral-out stream bundle. The dsq signal exists only when
// INTEGRAL_SQ_EN is defined.
interface integral_image_stream_if
    import integral_pkg::*;
#(
    parameter int unsigned DIN_W  = DEF_DIN_W,
    parameter int unsigned DOUT_W = DEF_DOUT_W,
    parameter int unsigned DSQ_W  = DEF_DSQ_W,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned COLS   = DEF_COLS
);
    localparam int unsigned CW = col_w(COLS);
    localparam int unsigned RW = row_w(ROWS);

    logic [DIN_W-1:0]  din;
    logic              din_valid;
    logic              din_sof;
    logic [DOUT_W-1:0] dout;
    logic              dout_valid;
    logic [CW-1:0]     o_col_cnt;
    logic [RW-1:0]     o_row_cnt;
    logic              o_eof;
`ifdef INTEGRAL_SQ_EN
    logic [DSQ_W-1:0]  dsq;

    modport master (
        output din, din_valid, din_sof,
        input  dout, dout_valid, o_col_cnt, o_row_cnt, o_eof, dsq
    );
    modport slave (
        input  din, din_valid, din_sof,
        output dout, dout_valid, o_col_cnt, o_row_cnt, o_eof, dsq
    );
`else
    modport master (
        output din, din_valid, din_sof,
        input  dout, dout_valid, o_col_cnt, o_row_cnt, o_eof
    );
    modport slave (
        input  din, din_valid, din_sof,
        output dout, dout_valid, o_col_cnt, o_row_cnt, o_eof
    );
`endif

endinterface

// File: rtl/integral_image_stream_line_mem.sv
// Simple dual-port line memory, DEPTH x WIDTH, registered read. Contents are
// deliberately not reset.
module integral_line_mem
    import integral_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_COLS,
    parameter int unsigned WIDTH = DEF_DOUT_W,
    localparam int unsigned AW   = col_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/integral_image_stream.sv
// Streaming integral image: two-stage pipeline (row accumulate + line-memory read,
// then column add). Optional squared plane enabled by macro INTEGRAL_SQ_EN.
module integral_image_stream
    import integral_pkg::*;
#(
    parameter int unsigned DIN_W  = DEF_DIN_W,
    parameter int unsigned DOUT_W = DEF_DOUT_W,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned DSQ_W  = DEF_DSQ_W
) (
    input logic                   clk,
    input logic                   rst,
    integral_image_stream_if.slave bus
);
    localparam int unsigned CW       = col_w(COLS);
    localparam int unsigned RW       = row_w(ROWS);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic [CW-1:0]     r_col, r_col1, r_col2, w_col;
    logic [RW-1:0]     r_row, r_row1, r_row2, w_row;
    logic [DOUT_W-1:0] r_racc, w_racc, w_prev, r_dout;
    logic              r_v1, r_v2, r_eof;

    // sof forces this pixel to (0,0) whatever the counters hold
    always_comb begin
        w_col  = bus.din_sof ? '0 : r_col;
        w_row  = bus.din_sof ? '0 : r_row;
        w_racc = (w_col == '0) ? DOUT_W'(bus.din) : r_racc + DOUT_W'(bus.din);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_col1 <= '0;
            r_row1 <= '0;
            r_racc <= '0;
            r_v1   <= 1'b0;
            r_col2 <= '0;
            r_row2 <= '0;
            r_dout <= '0;
            r_v2   <= 1'b0;
            r_eof  <= 1'b0;
        end else begin
            r_v1 <= bus.din_valid;
            if (bus.din_valid) begin
                r_col1 <= w_col;
                r_row1 <= w_row;
                r_racc <= w_racc;
                if (w_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= (w_row == LAST_ROW) ? '0 : w_row + RW'(1);
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
            end
            r_v2  <= r_v1;
            r_eof <= r_v1 && (r_col1 == LAST_COL) && (r_row1 == LAST_ROW);
            if (r_v1) begin
                r_col2 <= r_col1;
                r_row2 <= r_row1;
                // row 0 never looks at the line memory, so stale frames cannot leak in
                r_dout <= r_racc + ((r_row1 == '0) ? '0 : w_prev);
            end
        end
    end

    integral_line_mem #(
        .DEPTH (COLS),
        .WIDTH (DOUT_W)
    ) u_line_mem (
        .clk     (clk),
        .i_we    (r_v2),
        .i_waddr (r_col2),
        .i_wdata (r_dout),
        .i_re    (bus.din_valid),
        .i_raddr (w_col),
        .o_rdata (w_prev)
    );

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_v2;
    assign bus.o_col_cnt  = r_col2;
    assign bus.o_row_cnt  = r_row2;
    assign bus.o_eof      = r_eof;

`ifdef INTEGRAL_SQ_EN
    logic [DSQ_W-1:0] r_sacc, w_sacc, w_sq, w_sprev, r_dsq;

    always_comb begin
        w_sq   = DSQ_W'(bus.din) * DSQ_W'(bus.din);
        w_sacc = (w_col == '0) ? w_sq : r_sacc + w_sq;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sacc <= '0;
            r_dsq  <= '0;
        end else begin
            if (bus.din_valid) r_sacc <= w_sacc;
            if (r_v1) r_dsq <= r_sacc + ((r_row1 == '0) ? '0 : w_sprev);
        end
    end

    integral_line_mem #(
        .DEPTH (COLS),
        .WIDTH (DSQ_W)
    ) u_line_mem_sq (
        .clk     (clk),
        .i_we    (r_v2),
        .i_waddr (r_col2),
        .i_wdata (r_dsq),
        .i_re    (bus.din_valid),
        .i_raddr (w_col),
        .o_rdata (w_sprev)
    );

    assign bus.dsq = r_dsq;
`endif

endmodule

// File: tb/tb_integral_image_stream.sv
// Directed bench for integral_image_stream on a 4x4 frame with DOUT_W=10 so that
// an all-255 frame wraps; dsq is checked only when INTEGRAL_SQ_EN is defined.
module tb_integral_image_stream;
    localparam int unsigned DIN_W  = 8;
    localparam int unsigned DOUT_W = 10;
    localparam int unsigned DSQ_W  = 36;
    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int          MODW   = 1 << DOUT_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    integral_image_stream_if #(
        .DIN_W  (DIN_W),
        .DOUT_W (DOUT_W),
        .DSQ_W  (DSQ_W),
        .ROWS   (ROWS),
        .COLS   (COLS)
    ) bus ();

    integral_image_stream #(
        .DIN_W  (DIN_W),
        .DOUT_W (DOUT_W),
        .ROWS   (ROWS),
        .COLS   (COLS),
        .DSQ_W  (DSQ_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit     v;
        int     d;
        int     c;
        int     r;
        longint sq;
        bit     sqc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t e1 = '{v: 1'b0, d: 0, c: 0, r: 0, sq: 0, sqc: 1'b0};
    exp_t e2 = '{v: 1'b0, d: 0, c: 0, r: 0, sq: 0, sqc: 1'b0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive a pixel, then check the output due from two pixels-slots ago.
    task automatic step(input bit v, input int d, input bit s, input int ed, input int ec,
                        input int er, input longint esq, input bit sqc);
        bit rst_s;
        bus.din       = DIN_W'(d);
        bus.din_valid = v;
        bus.din_sof   = s;
        rst_s = rst;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.din_sof   = 1'b0;
        e2 = e1;
        e1 = '{v: v && rst_s, d: ed, c: ec, r: er, sq: esq, sqc: sqc};
        if (!rst_s) begin
            e1.v = 1'b0;
            e2.v = 1'b0;
            chk("rst_valid", 64'(bus.dout_valid), 64'd0);
            chk("rst_dout", 64'(bus.dout), 64'd0);
            chk("rst_col", 64'(bus.o_col_cnt), 64'd0);
            chk("rst_row", 64'(bus.o_row_cnt), 64'd0);
            chk("rst_eof", 64'(bus.o_eof), 64'd0);
`ifdef INTEGRAL_SQ_EN
            chk("rst_dsq", 64'(bus.dsq), 64'd0);
`endif
        end else begin
            chk("dout_valid", 64'(bus.dout_valid), 64'(e2.v));
            chk("eof", 64'(bus.o_eof),
                64'(e2.v && e2.c == int'(COLS - 1) && e2.r == int'(ROWS - 1)));
            if (e2.v) begin
                chk("dout", 64'(bus.dout), 64'(e2.d));
                chk("col", 64'(bus.o_col_cnt), 64'(e2.c));
                chk("row", 64'(bus.o_row_cnt), 64'(e2.r));
`ifdef INTEGRAL_SQ_EN
                if (e2.sqc) chk("dsq", 64'(bus.dsq), 64'(e2.sq));
`endif
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    // kind: 0 all ones, 1 ramp x+4y, 2 all 255, 3 all twos
    task automatic pixel(input int kind, input int x, input int y, input bit sof);
        int     d;
        int     n;
        int     ed;
        longint esq;
        bit     sqc;
        n   = (x + 1) * (y + 1);
        sqc = 1'b1;
        case (kind)
            0: begin d = 1;   ed = n;       esq = n;          end
            1: begin
                d   = x + 4 * y;
                ed  = (y + 1) * x * (x + 1) / 2 + 2 * (x + 1) * y * (y + 1);
                esq = 0;
                sqc = 1'b0;
            end
            2: begin d = 255; ed = 255 * n; esq = 65025 * n;  end
            default: begin d = 2; ed = 2 * n; esq = 4 * n;    end
        endcase
        step(1'b1, d, sof, ed % MODW, x, y, esq, sqc);
    endtask

    task automatic frame(input int kind, input bit gaps, input bit sof);
        for (int y = 0; y < int'(ROWS); y++) begin
            for (int x = 0; x < int'(COLS); x++) begin
                if (gaps) repeat ($urandom_range(0, 3)) idle();
                pixel(kind, x, y, sof && x == 0 && y == 0);
            end
        end
    endtask

    initial begin
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.din_sof   = 1'b0;

        // reset state
        idle();
        idle();
        rst = 1'b1;
        idle();

        // all ones: (x+1)(y+1), eof at (3,3)=16
        frame(0, 1'b0, 1'b1);
        idle();
        idle();

        // ramp, back-to-back pixels, then with random gaps
        frame(1, 1'b0, 1'b1);
        idle();
        frame(1, 1'b1, 1'b1);
        idle();
        idle();

        // sof at pixel 7 restarts at (0,0) with din=5, rest of that frame ones
        for (int k = 0; k < 7; k++) pixel(0, k % 4, k / 4, k == 0);
        step(1'b1, 5, 1'b1, 5, 0, 0, 25, 1'b1);
        for (int k = 1; k < 16; k++) begin
            step(1'b1, 1, 1'b0, ((k % 4) + 1) * ((k / 4) + 1) + 4, k % 4, k / 4,
                 longint'(((k % 4) + 1) * ((k / 4) + 1) + 24), 1'b1);
        end
        frame(0, 1'b0, 1'b1);
        idle();
        idle();

        // reset during row 2; next frame has no sof and must start at (0,0)
        for (int k = 0; k < 10; k++) pixel(0, k % 4, k / 4, k == 0);
        rst = 1'b0;
        repeat (3) step(1'b1, 1, 1'b0, 0, 0, 0, 0, 1'b0);
        rst = 1'b1;
        frame(0, 1'b0, 1'b0);
        idle();
        idle();

        // back-to-back frames; the 255 frame wraps modulo 1024
        frame(1, 1'b0, 1'b1);
        frame(2, 1'b0, 1'b1);
        idle();
        idle();

`ifdef INTEGRAL_SQ_EN
        frame(3, 1'b0, 1'b1);
        idle();
        idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
